nibble_frame_rx: RTL and testbench
==================================

NIBBLE_FRAME_RX -- requirements
Module: nibble_frame_rx

Interface
REQ-001 Parameters SHALL be:
- PARITY_EN, default 1: 1 = a trailing parity nibble is expected; 0 = no parity nibble.
- CNT_W, default 8: width of the statistics counters.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  nibble offered.
- in_ready  out  1  nibble accepted when in_valid && in_ready.
- in_data  in  4  nibble payload.
- in_last  in  1  marks the final nibble of a frame.
- frame_valid  out  1  assembled frame available.
- frame_ready  in  1  consumer takes the frame.
- frame_data  out  logic [3:0][2:3][3:0][1:4]  128-bit assembled frame.
- frame_err  out  2  00 ok, 01 parity mismatch, 10 framing error.
- good_cnt  out  CNT_W  count of frames with frame_err=00.
- err_cnt  out  CNT_W  count of frames with frame_err!=00.

REQ-003 The block SHALL be the receive end of the 32-nibble frame stream: 32 data nibbles, optionally followed by 1 parity nibble.

Function
REQ-004 States SHALL be COLLECT, PARITY, DRAIN and HOLD.
REQ-005 in_ready SHALL be 1 in COLLECT, PARITY and DRAIN, and 0 in HOLD.
REQ-006 frame_valid SHALL be 1 exactly in HOLD.
REQ-007 Accepted data nibble k (k=0..31) SHALL be written to frame_data[127-4k -: 4], so nibble 0 fills element [3][2][3][1:4].
REQ-008 Within a nibble, in_data[3] SHALL map to element index 1.
REQ-009 The running parity SHALL be the bitwise XOR of all accepted data nibbles of the current frame.
REQ-010 COLLECT: each accepted nibble SHALL increment the 5-bit index k.
REQ-011 COLLECT, in_last with k<31: go to HOLD with frame_err=10; unfilled bits stay 0.
REQ-012 COLLECT, k=31 without in_last: go to PARITY if PARITY_EN=1, else to DRAIN with frame_err=10 latched.
REQ-013 COLLECT, k=31 with in_last: go to HOLD with frame_err=00 if PARITY_EN=0, else frame_err=10 (parity nibble missing).
REQ-014 PARITY, accepted nibble with in_last: go to HOLD with frame_err=00 if the nibble equals the running parity, else 01.
REQ-015 PARITY, accepted nibble without in_last: go to DRAIN with frame_err=10 latched.
REQ-016 DRAIN: accepted nibbles SHALL be discarded and frame_data left unchanged; in_last SHALL move to HOLD with frame_err=10.
REQ-017 HOLD: frame_data and frame_err SHALL stay stable while frame_valid && !frame_ready.
REQ-018 HOLD with frame_ready=1: go to COLLECT next cycle; clear frame_data, parity and k in that same edge.
REQ-019 Latency SHALL be one cycle: frame_valid rises on the edge after acceptance of the terminating nibble.
REQ-020 No nibble SHALL be accepted in the cycle the frame is released; the next frame's first nibble is accepted one cycle after frame_ready.
REQ-021 On entry to HOLD, exactly one of good_cnt or err_cnt SHALL increment.
REQ-022 Both counters SHALL saturate at all-ones.
REQ-023 frame_err SHALL be 00 outside HOLD.
REQ-024 in_data and in_last SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL be in: state COLLECT, k=0, parity=0, frame_data=0, frame_err=00, good_cnt=0, err_cnt=0, frame_valid=0, in_ready=1.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame without incrementing any counter.
REQ-027 The first nibble SHALL be acceptable on the first rising clk edge after rst_n deasserts.

Verification
REQ-028 Good frame, PARITY_EN=1: nibbles 0x0..0xF,0x0..0xF, then parity 0x0 with in_last -> frame_data=128'h0123456789ABCDEF0123456789ABCDEF, frame_err=00, good_cnt=1.
REQ-029 Same data, parity nibble 0x5 -> frame_err=01, err_cnt=1, frame_data unchanged.
REQ-030 in_last on nibble 3, data 0xA,0xB,0xC,0xD -> frame_err=10, frame_data=128'hABCD followed by 112 zero bits, err_cnt increments.
REQ-031 Parity nibble sent without in_last, then 3 extra nibbles, last with in_last -> DRAIN, then HOLD with frame_err=10, frame_data holds the 32 data nibbles.
REQ-032 frame_ready held 0 for 10 cycles in HOLD -> in_ready=0 and outputs stable throughout; frame_ready=1 -> frame_valid=0 next cycle and the next frame is received correctly.
REQ-033 rst_n pulsed low after nibble 20 -> all outputs at reset values immediately, counters unchanged at 0, and the following good frame gives good_cnt=1.

Source files
------------

// File: rtl/nibble_frame_rx.sv
// Receive end of the 32-nibble frame stream: assembles 32 data nibbles into a
// 128-bit frame, checks the optional trailing parity nibble and keeps frame statistics.
module nibble_frame_rx #(
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_data,
    input  logic                        in_last,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [3:0][2:3][3:0][1:4]   frame_data,
    output logic [1:0]                  frame_err,
    output logic [CNT_W-1:0]            good_cnt,
    output logic [CNT_W-1:0]            err_cnt
);

    typedef enum logic [1:0] {COLLECT, PARITY, DRAIN, HOLD} state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_PAR   = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;

    state_t       state;
    logic [4:0]   k;
    logic [3:0]   parity;
    logic [127:0] data_q;
    logic         accept;
    logic         enter_hold;
    logic [1:0]   hold_err;

    assign in_ready    = (state != HOLD);
    assign frame_valid = (state == HOLD);
    assign accept      = in_valid && in_ready;
    // Flat storage: nibble k lands at bits [127-4k -: 4]; the packed view
    // makes element index 1 of each nibble its MSB.
    assign frame_data  = data_q;

    // Decode of the terminating nibble: whether this edge enters HOLD, and
    // with which error code. Shared by the FSM and the statistics counters.
    always_comb begin
        enter_hold = 1'b0;
        hold_err   = ERR_FRAME;
        if (accept && in_last) begin
            case (state)
                COLLECT: begin
                    enter_hold = 1'b1;
                    hold_err   = (k == 5'd31 && PARITY_EN == 0) ? ERR_OK : ERR_FRAME;
                end
                PARITY: begin
                    enter_hold = 1'b1;
                    hold_err   = (in_data == parity) ? ERR_OK : ERR_PAR;
                end
                DRAIN: begin
                    enter_hold = 1'b1;
                    hold_err   = ERR_FRAME;
                end
                default: ;
            endcase
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            k         <= '0;
            parity    <= '0;
            data_q    <= '0;
            frame_err <= ERR_OK;
            good_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            if (enter_hold) begin
                state     <= HOLD;
                frame_err <= hold_err;
                if (hold_err == ERR_OK) begin
                    if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
                end else begin
                    if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                end
            end

            case (state)
                COLLECT: begin
                    if (accept) begin
                        data_q[7'd127 - {k, 2'b00} -: 4] <= in_data;
                        parity <= parity ^ in_data;
                        k      <= k + 5'd1;
                        if (!in_last && k == 5'd31)
                            state <= (PARITY_EN != 0) ? PARITY : DRAIN;
                    end
                end
                PARITY: begin
                    if (accept && !in_last) state <= DRAIN;
                end
                DRAIN: ;
                HOLD: begin
                    // Release clears the frame so the next one starts from zeros.
                    if (frame_ready) begin
                        state     <= COLLECT;
                        data_q    <= '0;
                        parity    <= '0;
                        k         <= '0;
                        frame_err <= ERR_OK;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_frame_rx.sv
// Directed self-checking bench for nibble_frame_rx (PARITY_EN=1, CNT_W=8).
module tb_nibble_frame_rx;

    logic                      clk;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [3:0]                in_data;
    logic                      in_last;
    logic                      frame_valid;
    logic                      frame_ready;
    logic [3:0][2:3][3:0][1:4] frame_data;
    logic [1:0]                frame_err;
    logic [7:0]                good_cnt;
    logic [7:0]                err_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PATTERN = 128'h0123456789ABCDEF0123456789ABCDEF;

    nibble_frame_rx #(.PARITY_EN(1), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one nibble and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [3:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: nibble i = i mod 16; mode 1: nibble i = 3*i mod 16.
    function automatic logic [3:0] nib(input int mode, input int i);
        return (mode == 0) ? 4'(i) : 4'(3 * i);
    endfunction

    task automatic send_data(input int mode, input int count);
        for (int i = 0; i < count; i++) send(nib(mode, i), 1'b0);
    endtask

    task automatic release_frame;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        check("rel_valid", frame_valid, 0);
        check("rel_ready", in_ready, 1);
        check("rel_data", frame_data, 0);
        check("rel_err", frame_err, 0);
    endtask

    logic [127:0] exp_data;
    logic [127:0] snap_data;
    logic [3:0]   exp_par;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        #12;
        check("rst_valid", frame_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_data", frame_data, 0);
        check("rst_err", frame_err, 0);
        check("rst_good", good_cnt, 0);
        check("rst_errcnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good frame, parity 0x0.
        send_data(0, 32);
        check("par_state_ready", in_ready, 1);
        check("par_state_valid", frame_valid, 0);
        send(4'h0, 1'b1);
        check("good_valid", frame_valid, 1);
        check("good_data", frame_data, PATTERN);
        check("good_err", frame_err, 2'b00);
        check("good_cnt", good_cnt, 1);
        check("good_errcnt", err_cnt, 0);

        // Hold with frame_ready low: everything stable, no input accepted.
        in_valid = 1'b1;
        in_data  = 4'h7;
        in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_ready", in_ready, 0);
            check("hold_valid", frame_valid, 1);
            check("hold_data", frame_data, PATTERN);
            check("hold_err", frame_err, 2'b00);
            check("hold_cnt", {good_cnt, err_cnt}, {8'd1, 8'd0});
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_frame();

        // Same data, wrong parity nibble.
        send_data(0, 32);
        send(4'h5, 1'b1);
        check("badpar_valid", frame_valid, 1);
        check("badpar_err", frame_err, 2'b01);
        check("badpar_data", frame_data, PATTERN);
        check("badpar_errcnt", err_cnt, 1);
        check("badpar_good", good_cnt, 1);
        release_frame();

        // Short frame, with ignored in_last while in_valid is low.
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("idle_valid", frame_valid, 0);
        send(4'hD, 1'b1);
        check("short_valid", frame_valid, 1);
        check("short_err", frame_err, 2'b10);
        check("short_data", frame_data, {16'hABCD, 112'h0});
        check("short_errcnt", err_cnt, 2);
        release_frame();

        // Parity nibble without in_last, then three extras -> DRAIN then HOLD.
        exp_data = '0;
        exp_par  = '0;
        for (int i = 0; i < 32; i++) begin
            exp_data[127 - 4*i -: 4] = nib(1, i);
            exp_par ^= nib(1, i);
        end
        send_data(1, 32);
        send(exp_par, 1'b0);
        check("drain_ready", in_ready, 1);
        check("drain_valid", frame_valid, 0);
        check("drain_err", frame_err, 2'b00);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        check("drain_data", frame_data, exp_data);
        send(4'h3, 1'b1);
        check("drain_hold_valid", frame_valid, 1);
        check("drain_hold_err", frame_err, 2'b10);
        check("drain_hold_data", frame_data, exp_data);
        check("drain_errcnt", err_cnt, 3);
        check("drain_good", good_cnt, 1);
        release_frame();

        // Reset pulsed mid-frame, away from the clock edge.
        send_data(0, 21);
        snap_data = frame_data;
        check("mid_partial", snap_data[127:44], PATTERN[127:44]);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_data", frame_data, 0);
        check("mid_rst_err", frame_err, 0);
        check("mid_rst_cnt", {good_cnt, err_cnt}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_data(0, 32);
        send(4'h0, 1'b1);
        check("post_rst_data", frame_data, PATTERN);
        check("post_rst_err", frame_err, 2'b00);
        check("post_rst_cnt", {good_cnt, err_cnt}, {8'd1, 8'd0});
        release_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
